// File: rtl/riscv8bit_pkg.sv
// Shared definitions for the riscv8bit core bring-up logic: default widths and the
// self-test controller's FSM state encoding.
package riscv8bit_pkg;

  localparam int unsigned DefaultDataW = 8;
  localparam int unsigned DefaultAddrW = 8;

  typedef enum logic [2:0] {
    StIdle,
    StCoreRst,
    StRfRst,
    StRun,
    StCheck,
    StDone
  } selftest_st_e;

endpackage

// File: rtl/selftest_compare.sv
// Registered comparison of memory read data against golden data, with a saturating
// mismatch counter and capture of the first mismatch.
module selftest_compare #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned ERR_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              rd_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] chk_data_i,
  input  logic [DATA_W-1:0] exp_data_i,
  output logic [ERR_W-1:0]  err_count_o,
  output logic [ADDR_W-1:0] first_err_addr_o,
  output logic [DATA_W-1:0] first_err_got_o,
  output logic [DATA_W-1:0] first_err_exp_o
);

  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [ADDR_W-1:0] fa_q, fa_d;
  logic [DATA_W-1:0] fg_q, fg_d;
  logic [DATA_W-1:0] fe_q, fe_d;
  logic              mismatch;

  // Read data for the address issued last cycle arrives now.
  assign mismatch = rd_q && (chk_data_i != exp_data_i);

  always_comb begin
    rd_d    = rd_i;
    raddr_d = addr_i;
    err_d   = err_q;
    fa_d    = fa_q;
    fg_d    = fg_q;
    fe_d    = fe_q;
    if (mismatch) begin
      if (err_q != '1) err_d = err_q + ERR_W'(1);
      if (err_q == '0) begin
        fa_d = raddr_q;
        fg_d = chk_data_i;
        fe_d = exp_data_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      rd_q    <= 1'b0;
      raddr_q <= '0;
      err_q   <= '0;
      fa_q    <= '0;
      fg_q    <= '0;
      fe_q    <= '0;
    end else begin
      rd_q    <= rd_d;
      raddr_q <= raddr_d;
      err_q   <= err_d;
      fa_q    <= fa_d;
      fg_q    <= fg_d;
      fe_q    <= fe_d;
    end
  end

  assign err_count_o      = err_q;
  assign first_err_addr_o = fa_q;
  assign first_err_got_o  = fg_q;
  assign first_err_exp_o  = fe_q;

endmodule

// File: rtl/riscv_selftest_ctrl.sv
// Bring-up sequencer for the riscv8bit core: reset phases, timed free run, then a
// read-back check of a data-memory window against golden values.
module riscv_selftest_ctrl
  import riscv8bit_pkg::*;
#(
  parameter int unsigned DATA_W          = DefaultDataW,
  parameter int unsigned ADDR_W          = DefaultAddrW,
  parameter int unsigned CORE_RST_CYCLES = 1,
  parameter int unsigned RF_RST_CYCLES   = 3,
  parameter int unsigned RUN_CYCLES      = 121,
  parameter int unsigned CHECK_FIRST     = 1,
  parameter int unsigned CHECK_COUNT     = 12,
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned ERR_W           = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic              core_rst_o,
  output logic              rf_rst_o,
  output logic              mem_sel_o,
  output logic              chk_rd_o,
  output logic [ADDR_W-1:0] chk_addr_o,
  input  logic [DATA_W-1:0] chk_data_i,
  input  logic [DATA_W-1:0] exp_data_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [ERR_W-1:0]  err_count_o,
  output logic [ADDR_W-1:0] first_err_addr_o,
  output logic [DATA_W-1:0] first_err_got_o,
  output logic [DATA_W-1:0] first_err_exp_o
);

  if (64'(CHECK_FIRST) + 64'(CHECK_COUNT) > (64'd1 << ADDR_W)) begin : g_bad_window
    $error("check window exceeds the data-memory address range");
  end

  localparam logic [CNT_W-1:0]  CntCore   = CNT_W'(CORE_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CntRf     = CNT_W'(RF_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CntRun    = CNT_W'(RUN_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CntCheck  = CNT_W'(CHECK_COUNT);
  localparam logic [ADDR_W-1:0] AddrFirst = ADDR_W'(CHECK_FIRST);

  selftest_st_e      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              start_q;
  logic              clr;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    clr     = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_q) begin
          state_d = StCoreRst;
          cnt_d   = CntCore;
          clr     = 1'b1;
        end
      end
      StCoreRst: begin
        if (cnt_q == '0) begin
          if (RF_RST_CYCLES == 0) begin
            state_d = StRun;
            cnt_d   = CntRun;
          end else begin
            state_d = StRfRst;
            cnt_d   = CntRf;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StRfRst: begin
        if (cnt_q == '0) begin
          state_d = StRun;
          cnt_d   = CntRun;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StRun: begin
        if (cnt_q == '0) begin
          state_d = StCheck;
          cnt_d   = CntCheck;
          addr_d  = AddrFirst;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StCheck: begin
        // Counter runs K..0: reads on the nonzero counts, final cycle drains the compare.
        if (cnt_q == '0) begin
          state_d = StDone;
        end else begin
          cnt_d  = cnt_q - CNT_W'(1);
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      start_q <= start_i && (state_q == StIdle || state_q == StDone);
    end
  end

  always_comb begin
    core_rst_o = 1'b0;
    rf_rst_o   = 1'b0;
    mem_sel_o  = 1'b0;
    chk_rd_o   = 1'b0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    unique case (state_q)
      StIdle: begin
        core_rst_o = 1'b1;
        rf_rst_o   = 1'b1;
      end
      StCoreRst: begin
        core_rst_o = 1'b1;
        rf_rst_o   = 1'b1;
        busy_o     = 1'b1;
      end
      StRfRst: begin
        rf_rst_o = 1'b1;
        busy_o   = 1'b1;
      end
      StRun: busy_o = 1'b1;
      StCheck: begin
        mem_sel_o = 1'b1;
        chk_rd_o  = (cnt_q != '0);
        busy_o    = 1'b1;
      end
      StDone: done_o = 1'b1;
      default: ;
    endcase
  end

  assign chk_addr_o = addr_q;
  assign pass_o     = done_o && (err_count_o == '0);

  selftest_compare #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .ERR_W (ERR_W)
  ) u_compare (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .clr_i           (clr),
    .rd_i            (chk_rd_o),
    .addr_i          (addr_q),
    .chk_data_i      (chk_data_i),
    .exp_data_i      (exp_data_i),
    .err_count_o     (err_count_o),
    .first_err_addr_o(first_err_addr_o),
    .first_err_got_o (first_err_got_o),
    .first_err_exp_o (first_err_exp_o)
  );

endmodule

// File: tb/tb_riscv_selftest_ctrl.sv
// Bench for riscv_selftest_ctrl: three configurations run side by side against a
// phase-arithmetic timing model and a memory/golden mismatch model.
module tb_riscv_selftest_ctrl;

  localparam int C = 1;
  localparam int R = 3;
  localparam int N = 121;
  localparam int K = 12;
  localparam int F = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start;
  logic [7:0] mem  [256];
  logic [7:0] gold [256];

  logic cr0, rr0, ms0, rd0, busy0, done0, pass0;
  logic [7:0] a0, d0, e0, err0, fa0, fg0, fe0;
  logic cr1, rr1, ms1, rd1, busy1, done1, pass1;
  logic [7:0] a1, d1, e1, fa1, fg1, fe1;
  logic [1:0] err1;
  logic cr2, rr2, ms2, rd2, busy2, done2, pass2;
  logic [7:0] a2, d2, e2, err2, fa2, fg2, fe2;

  riscv_selftest_ctrl u_dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .core_rst_o(cr0), .rf_rst_o(rr0),
    .mem_sel_o(ms0), .chk_rd_o(rd0), .chk_addr_o(a0), .chk_data_i(d0), .exp_data_i(e0),
    .busy_o(busy0), .done_o(done0), .pass_o(pass0), .err_count_o(err0),
    .first_err_addr_o(fa0), .first_err_got_o(fg0), .first_err_exp_o(fe0)
  );

  riscv_selftest_ctrl #(.ERR_W(2)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .core_rst_o(cr1), .rf_rst_o(rr1),
    .mem_sel_o(ms1), .chk_rd_o(rd1), .chk_addr_o(a1), .chk_data_i(d1), .exp_data_i(e1),
    .busy_o(busy1), .done_o(done1), .pass_o(pass1), .err_count_o(err1),
    .first_err_addr_o(fa1), .first_err_got_o(fg1), .first_err_exp_o(fe1)
  );

  riscv_selftest_ctrl #(.RF_RST_CYCLES(0), .CHECK_COUNT(0)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .core_rst_o(cr2), .rf_rst_o(rr2),
    .mem_sel_o(ms2), .chk_rd_o(rd2), .chk_addr_o(a2), .chk_data_i(d2), .exp_data_i(e2),
    .busy_o(busy2), .done_o(done2), .pass_o(pass2), .err_count_o(err2),
    .first_err_addr_o(fa2), .first_err_got_o(fg2), .first_err_exp_o(fe2)
  );

  // One-cycle-latency data memory and golden source per instance.
  always @(posedge clk) begin
    d0 <= mem[a0]; e0 <= gold[a0];
    d1 <= mem[a1]; e1 <= gold[a1];
    d2 <= mem[a2]; e2 <= gold[a2];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected {core_rst, rf_rst, busy, mem_sel, chk_rd, done, chk_addr} k edges after start.
  function automatic logic [13:0] exp_ctl(input int c, input int r, input int n, input int kk,
                                          input int k);
    logic cr, rr, b, ms, rd, dn;
    logic [7:0] a;
    int run_end;
    cr = 0; rr = 0; b = 0; ms = 0; rd = 0; dn = 0; a = 8'h0;
    run_end = c + r + n;
    if (k <= 0) begin
      cr = 1; rr = 1;
    end else if (k <= c) begin
      cr = 1; rr = 1; b = 1;
    end else if (k <= c + r) begin
      rr = 1; b = 1;
    end else if (k <= run_end) begin
      b = 1;
    end else if (k <= run_end + kk + 1) begin
      b = 1; ms = 1;
      if (k - run_end - 1 < kk) begin
        rd = 1;
        a  = 8'(F + k - run_end - 1);
      end
    end else begin
      dn = 1;
    end
    return {cr, rr, b, ms, rd, dn, a};
  endfunction

  task automatic model_res(input int cnt, input int sat, output int ec, output int fa,
                           output int fg, output int fe);
    ec = 0; fa = 0; fg = 0; fe = 0;
    for (int i = 0; i < cnt; i++) begin
      if (mem[F+i] !== gold[F+i]) begin
        if (ec == 0) begin
          fa = F + i; fg = mem[F+i]; fe = gold[F+i];
        end
        if (ec < sat) ec++;
      end
    end
  endtask

  task automatic check_ctl(input int k);
    logic [13:0] x;
    x = exp_ctl(C, R, N, K, k);
    chk($sformatf("u0 ctl k=%0d", k), {cr0, rr0, busy0, ms0, rd0, done0, x[9] ? a0 : 8'h0}, x);
    chk($sformatf("u1 ctl k=%0d", k), {cr1, rr1, busy1, ms1, rd1, done1, x[9] ? a1 : 8'h0}, x);
    x = exp_ctl(C, 0, N, 0, k);
    chk($sformatf("u2 ctl k=%0d", k), {cr2, rr2, busy2, ms2, rd2, done2, x[9] ? a2 : 8'h0}, x);
  endtask

  task automatic check_res(input string tag);
    int ec, fa, fg, fe;
    model_res(K, 255, ec, fa, fg, fe);
    chk({tag, " u0 err_count"}, err0, ec);
    chk({tag, " u0 first_addr"}, fa0, fa);
    chk({tag, " u0 first_got"}, fg0, fg);
    chk({tag, " u0 first_exp"}, fe0, fe);
    chk({tag, " u0 pass"}, pass0, (ec == 0));
    model_res(K, 3, ec, fa, fg, fe);
    chk({tag, " u1 err_count"}, err1, ec);
    chk({tag, " u1 first_addr"}, fa1, fa);
    chk({tag, " u1 pass"}, pass1, (ec == 0));
    chk({tag, " u2 results"}, {err2, fa2, fg2, fe2, pass2}, 33'h1);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " u0 ctl"}, {cr0, rr0, busy0, ms0, rd0, done0}, 6'b110000);
    chk({tag, " u0 results"}, {err0, fa0, fg0, fe0, pass0}, 33'h0);
    chk({tag, " u1 err_count"}, err1, 0);
    chk({tag, " u2 ctl"}, {cr2, rr2, busy2, ms2, rd2, done2}, 6'b110000);
  endtask

  task automatic run_seq(input int abort_k, input int pulse_k);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= C + R + N + K + 3; k++) begin
      @(negedge clk);
      start = (k == pulse_k);
      check_ctl(k);
      if (k == 1) chk("cleared on start", {err0, fa0, fg0, fe0, err1}, 34'h0);
      if (k == abort_k) begin
        rst = 1'b1;
        @(negedge clk);
        check_idle($sformatf("abort k=%0d", k));
        rst = 1'b0;
        return;
      end
    end
    start = 1'b0;
  endtask

  task automatic scramble(input int odds);
    for (int i = 0; i < 256; i++) begin
      mem[i]  = 8'($urandom);
      gold[i] = mem[i];
      if ($urandom_range(0, 99) < odds) gold[i] = mem[i] ^ 8'($urandom_range(1, 255));
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    scramble(0);
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;

    // Matching window.
    scramble(0);
    run_seq(-1, -1);
    check_res("match");

    // Two mismatches; start pulsed mid-RUN must be ignored.
    scramble(0);
    mem[5]  = 8'h00;
    gold[5] = 8'h34;
    gold[9] = mem[9] ^ 8'h5a;
    run_seq(-1, 50);
    check_res("two errs");
    chk("two errs fixed addr", fa0, 5);
    repeat (5) @(negedge clk);
    chk("two errs hold done", {done0, busy0}, 2'b10);
    check_res("two errs hold");

    // Every address mismatches: narrow counter saturates. Started from DONE.
    scramble(100);
    run_seq(-1, -1);
    check_res("all errs");
    chk("all errs u1 saturated", err1, 3);

    // Abort while reading address 7, then a clean restart from IDLE.
    scramble(30);
    run_seq(C + R + N + 7, -1);
    scramble(30);
    run_seq(-1, -1);
    check_res("after abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
